// File: rtl/bus_arbiter_pkg.sv
// Shared bus widths, arbiter state encoding and arbitration defaults.
// Imported by the interface and the arbiter.
package bus_arbiter_pkg;

    localparam int ADDR_W           = 32;
    localparam int DATA_W           = 32;
    localparam int SEL_W            = 4;
    localparam int STARVE_LIMIT_DEF = 2;
    localparam int TIMEOUT_DEF      = 255;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_I_BUSY = 2'd1,
        ST_D_BUSY = 2'd2,
        ST_I_DROP = 2'd3
    } arb_state_e;

    function automatic logic [SEL_W-1:0] sel_all();
        return {SEL_W{1'b1}};
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// External shared-bus bundle between the arbiter (master)
// and the memory/peripheral side (slave).
interface bus_arbiter_if;
    import bus_arbiter_pkg::*;

    logic              stb;
    logic              we;
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (
        output stb, we, sel, addr, wdata,
        input  rdata, ack
    );

    modport slave (
        input  stb, we, sel, addr, wdata,
        output rdata, ack
    );

endinterface

// File: rtl/bus_arbiter.sv
// Fetch/data arbiter onto one shared bus, with fetch starvation guard.
// Optional bus watchdog enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
    parameter int STARVE_LIMIT   = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic [DATA_W-1:0] i_data_o,
    output logic              i_ack_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [SEL_W-1:0]  d_sel_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_ack_o,
    input  logic              flush_i,
    output logic              err_o,
    output logic              stallreq_o,
    bus_arbiter_if.master     bus
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_e        state_q;
    logic              stb_q;
    logic              we_q;
    logic [SEL_W-1:0]  sel_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] i_data_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              i_ack_q;
    logic              d_ack_q;
    logic [SW-1:0]     starve_q;

    logic idle_ok;
    logic i_elig;
    logic starved;
    logic i_grant;
    logic d_grant;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_q;
    logic          err_q;
    logic          to_fire;

    assign to_fire = (to_q == TW'(TIMEOUT_CYCLES - 1));
    assign err_o   = err_q;
`else
    logic unused_cfg;

    assign unused_cfg = (TIMEOUT_CYCLES > 0);
    assign err_o      = 1'b0;
`endif

    // Any ack cycle is a bus turnaround: no grant to either side.
    assign idle_ok = (state_q == ST_IDLE) && !i_ack_q && !d_ack_q;
    assign i_elig  = i_req_i && !flush_i;
    assign starved = (starve_q >= SW'(STARVE_LIMIT));
    assign i_grant = idle_ok && i_elig && (starved || !d_req_i);
    assign d_grant = idle_ok && d_req_i && !(i_elig && starved);

    assign stallreq_o = (i_req_i & ~i_ack_q) | (d_req_i & ~d_ack_q);

    assign i_data_o  = i_data_q;
    assign i_ack_o   = i_ack_q;
    assign d_rdata_o = d_rdata_q;
    assign d_ack_o   = d_ack_q;

    assign bus.stb   = stb_q;
    assign bus.we    = we_q;
    assign bus.sel   = sel_q;
    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_data_q  <= '0;
            d_rdata_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            starve_q  <= '0;
`ifdef ARB_TIMEOUT_EN
            to_q      <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            err_q   <= 1'b0;
            to_q    <= (state_q == ST_IDLE) ? '0 : to_q + TW'(1);
`endif
            unique case (state_q)
                ST_IDLE: begin
                    if (d_grant) begin
                        state_q <= ST_D_BUSY;
                        stb_q   <= 1'b1;
                        we_q    <= d_we_i;
                        sel_q   <= d_sel_i;
                        addr_q  <= d_addr_i;
                        wdata_q <= d_wdata_i;
                    end else if (i_grant) begin
                        state_q <= ST_I_BUSY;
                        stb_q   <= 1'b1;
                        we_q    <= 1'b0;
                        sel_q   <= sel_all();
                        addr_q  <= i_addr_i;
                        wdata_q <= '0;
                    end
                end
                ST_I_BUSY: begin
                    if (bus.ack) begin
                        state_q <= ST_IDLE;
                        stb_q   <= 1'b0;
                        if (!flush_i) begin
                            i_ack_q  <= 1'b1;
                            i_data_q <= bus.rdata;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (to_fire) begin
                        state_q <= ST_IDLE;
                        stb_q   <= 1'b0;
                        if (!flush_i) begin
                            i_ack_q  <= 1'b1;
                            err_q    <= 1'b1;
                            i_data_q <= '0;
                        end
                    end
`endif
                    else if (flush_i) begin
                        state_q <= ST_I_DROP;
                    end
                end
                ST_D_BUSY: begin
                    if (bus.ack) begin
                        state_q   <= ST_IDLE;
                        stb_q     <= 1'b0;
                        d_ack_q   <= 1'b1;
                        d_rdata_q <= bus.rdata;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (to_fire) begin
                        state_q   <= ST_IDLE;
                        stb_q     <= 1'b0;
                        d_ack_q   <= 1'b1;
                        err_q     <= 1'b1;
                        d_rdata_q <= '0;
                    end
`endif
                end
                ST_I_DROP: begin
                    // Flushed fetch: let the bus finish, report nothing.
                    if (bus.ack) begin
                        state_q <= ST_IDLE;
                        stb_q   <= 1'b0;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (to_fire) begin
                        state_q <= ST_IDLE;
                        stb_q   <= 1'b0;
                    end
`endif
                end
                default: state_q <= ST_IDLE;
            endcase

            if (!i_req_i || i_grant) begin
                starve_q <= '0;
            end else if (d_grant && !starved) begin
                starve_q <= starve_q + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: stimulus queues expected acks,
// a monitor pops and compares them on every i_ack_o/d_ack_o.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

`ifdef ARB_TIMEOUT_EN
    localparam int TB_TO = 4;
`else
    localparam int TB_TO = 255;
`endif

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_sel;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        flush;
    logic        err;
    logic        stallreq;

    exp_t        exp_q[$];
    int          chk_cnt = 0;
    int          pass_cnt = 0;
    int          rsp_delay = 0;
    logic [31:0] rsp_data = '0;
    bit          force_ack = 1'b0;
    int          stb_cnt = 0;

    bus_arbiter_if bus();

    bus_arbiter #(
        .TIMEOUT_CYCLES(TB_TO),
        .STARVE_LIMIT  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req_i   (i_req),
        .i_addr_i  (i_addr),
        .i_data_o  (i_data),
        .i_ack_o   (i_ack),
        .d_req_i   (d_req),
        .d_we_i    (d_we),
        .d_sel_i   (d_sel),
        .d_addr_i  (d_addr),
        .d_wdata_i (d_wdata),
        .d_rdata_o (d_rdata),
        .d_ack_o   (d_ack),
        .flush_i   (flush),
        .err_o     (err),
        .stallreq_o(stallreq),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic expect_ack(input bit is_d,
                              input logic [31:0] data,
                              input bit e);
        exp_t x;
        x.is_d = is_d;
        x.data = data;
        x.err  = e;
        exp_q.push_back(x);
    endtask

    // Bus slave: acks rsp_delay cycles after stb rises; -1 means never.
    initial begin
        bus.ack   = 1'b0;
        bus.rdata = '0;
        forever begin
            @(negedge clk);
            if (force_ack || (bus.stb && rsp_delay >= 0
                              && stb_cnt == rsp_delay)) begin
                bus.ack   = 1'b1;
                bus.rdata = rsp_data;
            end else begin
                bus.ack = 1'b0;
            end
            stb_cnt = bus.stb ? stb_cnt + 1 : 0;
        end
    end

    always @(negedge clk) begin : mon
        exp_t act;
        exp_t e;
        if (i_ack || d_ack) begin
            act.is_d = d_ack;
            act.data = d_ack ? d_rdata : i_data;
            act.err  = err;
            chk_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL ack_unexpected: got d=%0d data=%h err=%0d want none",
                         act.is_d, act.data, act.err);
            end else begin
                e = exp_q.pop_front();
                if (act === e) pass_cnt++;
                else $display("FAIL ack: got d=%0d data=%h err=%0d want d=%0d data=%h err=%0d",
                              act.is_d, act.data, act.err, e.is_d, e.data, e.err);
            end
        end
    end

    initial begin
        rst = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0;
        d_sel = 0; d_addr = 0; d_wdata = 0; flush = 0;
        repeat (3) tick();
        check("rst_stb", bus.stb, 0);
        check("rst_we", bus.we, 0);
        check("rst_sel", bus.sel, 0);
        check("rst_addr", bus.addr, 0);
        check("rst_wdata", bus.wdata, 0);
        check("rst_idata", i_data, 0);
        check("rst_drdata", d_rdata, 0);
        check("rst_acks", {i_ack, d_ack, err}, 0);
        rst = 1'b0;
        repeat (2) tick();

        // Minimum-latency fetch
        i_req = 1; i_addr = 32'h100; rsp_delay = 0;
        rsp_data = 32'h3C010001;
        expect_ack(0, 32'h3C010001, 0);
        tick();
        check("A_stb", bus.stb, 1);
        check("A_addr", bus.addr, 32'h100);
        check("A_we_sel", {bus.we, bus.sel}, 5'b01111);
        check("A_stall1", stallreq, 1);
        tick();
        check("A_iack", i_ack, 1);
        check("A_idata", i_data, 32'h3C010001);
        check("A_stall2", stallreq, 0);
        i_req = 0;
        repeat (2) tick();

        // Simultaneous requests: data first
        i_req = 1; i_addr = 32'h200;
        d_req = 1; d_we = 1; d_addr = 32'h40; d_sel = 4'b0011;
        d_wdata = 32'hDEADBEEF; rsp_data = 32'h11111111;
        expect_ack(1, 32'h11111111, 0);
        tick();
        check("B_addr", bus.addr, 32'h40);
        check("B_we_sel", {bus.stb, bus.we, bus.sel}, 6'b110011);
        check("B_wdata", bus.wdata, 32'hDEADBEEF);
        tick();
        check("B_dack", d_ack, 1);
        check("B_stb_gap", bus.stb, 0);
        d_req = 0; d_we = 0; rsp_data = 32'h22222222;
        expect_ack(0, 32'h22222222, 0);
        tick();
        tick();
        check("B_fetch_addr", bus.addr, 32'h200);
        check("B_fetch_we_sel", {bus.stb, bus.we, bus.sel}, 6'b101111);
        tick();
        check("B_iack", i_ack, 1);
        i_req = 0;
        repeat (2) tick();

        // Starvation: fetch after exactly two data grants
        i_req = 1; i_addr = 32'h300;
        d_req = 1; d_we = 0; d_sel = 4'hF; d_addr = 32'h80;
        rsp_data = 32'hA1;
        expect_ack(1, 32'hA1, 0);
        tick();
        check("C_g1", bus.addr, 32'h80);
        tick();
        check("C_gap1", bus.stb, 0);
        d_addr = 32'h84; rsp_data = 32'hA2;
        expect_ack(1, 32'hA2, 0);
        tick();
        tick();
        check("C_g2", bus.addr, 32'h84);
        tick();
        d_addr = 32'h88; rsp_data = 32'hB0;
        expect_ack(0, 32'hB0, 0);
        tick();
        tick();
        check("C_g3_fetch", {bus.stb, bus.addr}, {1'b1, 32'h300});
        tick();
        check("C_iack", i_ack, 1);
        i_req = 0; rsp_data = 32'hA3;
        expect_ack(1, 32'hA3, 0);
        tick();
        tick();
        check("C_g4", bus.addr, 32'h88);
        tick();
        d_req = 0;
        repeat (2) tick();

        // Flush mid-fetch, ack arrives later, pending data follows
        i_req = 1; i_addr = 32'h400; rsp_delay = 3;
        tick();
        tick();
        flush = 1; d_req = 1; d_we = 1; d_addr = 32'h500;
        d_sel = 4'hF; d_wdata = 32'h12345678;
        tick();
        flush = 0; i_req = 0;
        check("D_drop_stb", bus.stb, 1);
        tick();
        tick();
        check("D_c5", {bus.stb, i_ack}, 2'b00);
        rsp_delay = 0; rsp_data = 32'h77;
        expect_ack(1, 32'h77, 0);
        tick();
        check("D_dgrant", {bus.stb, bus.we, bus.addr},
              {2'b11, 32'h500});
        tick();
        d_req = 0; d_we = 0;
        repeat (2) tick();

        // Flush coincident with ack
        i_req = 1; i_addr = 32'h600; rsp_delay = 1; rsp_data = 32'hEE;
        tick();
        tick();
        flush = 1;
        tick();
        check("E_noack", {bus.stb, i_ack}, 2'b00);
        check("E_idata", i_data, 32'hB0);
        flush = 0; i_req = 0;
        repeat (2) tick();

        // Flush in IDLE blocks the fetch grant
        i_req = 1; i_addr = 32'h700; flush = 1; rsp_delay = 0;
        tick();
        check("F_blocked", bus.stb, 0);
        flush = 0; rsp_data = 32'h70;
        expect_ack(0, 32'h70, 0);
        tick();
        check("F_grant", {bus.stb, bus.addr}, {1'b1, 32'h700});
        tick();
        i_req = 0;
        repeat (2) tick();

        // Flush ignored during a data cycle
        d_req = 1; d_we = 0; d_addr = 32'h900; rsp_delay = 1;
        rsp_data = 32'h99;
        expect_ack(1, 32'h99, 0);
        tick();
        flush = 1;
        tick();
        tick();
        check("G_dack", d_ack, 1);
        flush = 0; d_req = 0;
        repeat (2) tick();

`ifdef ARB_TIMEOUT_EN
        d_req = 1; d_addr = 32'hB00; rsp_delay = -1;
        expect_ack(1, 32'h0, 1);
        repeat (4) tick();
        check("T_wait", {bus.stb, d_ack}, 2'b10);
        tick();
        check("T_ack", {d_ack, err}, 2'b11);
        check("T_data", d_rdata, 0);
        d_req = 0;
        repeat (2) tick();
`endif

        // Reset while in D_BUSY, late ack ignored
        d_req = 1; d_we = 1; d_addr = 32'hA00; rsp_delay = -1;
        tick();
        check("H_stb", bus.stb, 1);
        tick();
        rst = 1; d_req = 0; d_we = 0;
        tick();
        check("H_rst", {bus.stb, bus.we, d_ack, i_ack}, 0);
        check("H_rst_addr", bus.addr, 0);
        check("H_rst_rdata", d_rdata, 0);
        rst = 0; force_ack = 1;
        tick();
        force_ack = 0;
        tick();
        check("H_late_ack", {bus.stb, d_ack, i_ack}, 0);
        repeat (2) tick();

        check("drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
